// File: rtl/rv32i_types.sv
// ----------------------------------------------------------------------------
// rv32i_types
//   Shared type definitions for the memory-side arbitration logic.
//   arb_state_t : state encoding of the cache arbiter FSM. The same type is
//                 used by the grant picker to name the side it selects
//                 (SERVE_I / SERVE_D, or IDLE when nobody is requesting).
// ----------------------------------------------------------------------------
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/cache_arb_pick.sv
// ----------------------------------------------------------------------------
// cache_arb_pick
//   Combinational grant selection for the cache arbiter.
//   Ports:
//     i_req  in  1            I-cache wants a line
//     d_req  in  1            D-cache wants a line (read or writeback)
//     prio   in  1            tie-break: 0 -> D wins, 1 -> I wins
//     grant  out arb_state_t  SERVE_I, SERVE_D, or IDLE when nothing pending
// ----------------------------------------------------------------------------
module cache_arb_pick
    import rv32i_types::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  logic       prio,
    output arb_state_t grant
);

    // The tie-break flag only matters when both sides request together.
    always_comb begin
        grant = IDLE;
        if (i_req && d_req) begin
            grant = prio ? SERVE_I : SERVE_D;
        end else if (d_req) begin
            grant = SERVE_D;
        end else if (i_req) begin
            grant = SERVE_I;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// ----------------------------------------------------------------------------
// cache_arbiter
//   Shares the single cacheline-adaptor port between the I-cache miss path and
//   the D-cache miss/writeback path. One whole-line transfer outstanding at a
//   time; each completed transfer is followed by one RELEASE cycle so a
//   requester whose request is still high when it sees its resp is not served
//   a second time.
//
//   Configuration macro:
//     CACHE_ARB_RR_EN  defined   -> on simultaneous requests the side not
//                                   served last wins (1-bit priority flag).
//                      undefined -> fixed D-over-I priority.
//
//   Ports:
//     clk        in   1       clock
//     rst        in   1       asynchronous, active-low reset
//     i_read     in   1       I-cache line read request
//     i_addr     in   ADDR_W  I-cache line address
//     i_rdata    out  LINE_W  line returned to I-cache (broadcast of mem_rdata)
//     i_resp     out  1       completion pulse to I-cache
//     d_read     in   1       D-cache line read request
//     d_write    in   1       D-cache line writeback request
//     d_addr     in   ADDR_W  D-cache line address
//     d_wdata    in   LINE_W  writeback line
//     d_rdata    out  LINE_W  line returned to D-cache (broadcast of mem_rdata)
//     d_resp     out  1       completion pulse to D-cache
//     mem_read   out  1       read command to adaptor
//     mem_write  out  1       write command to adaptor
//     mem_addr   out  ADDR_W  address to adaptor
//     mem_wdata  out  LINE_W  write line to adaptor
//     mem_rdata  in   LINE_W  read line from adaptor
//     mem_resp   in   1       adaptor completion pulse
//     busy       out  1       high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              busy
);

    arb_state_t state_q;
    arb_state_t state_d;
    arb_state_t pick_grant;
    logic       prio;

    // Both caches see the adaptor data; each qualifies it with its own resp.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign busy    = (state_q != IDLE);

`ifdef CACHE_ARB_RR_EN
    logic prio_q;
    logic prio_d;

    // The flag points away from whichever side just completed, so on the
    // next tie the other side is served.
    always_comb begin
        prio_d = prio_q;
        if (mem_resp && state_q == SERVE_D) begin
            prio_d = 1'b1;
        end else if (mem_resp && state_q == SERVE_I) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign prio = prio_q;
`else
    // Fixed priority: a tie always goes to the D-cache.
    assign prio = 1'b0;
`endif

    cache_arb_pick u_pick (
        .i_req (i_read),
        .d_req (d_read | d_write),
        .prio  (prio),
        .grant (pick_grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests are only sampled in IDLE; RELEASE ignores the still-high
    // request of the side that just completed. mem_resp outside a SERVE
    // state has no effect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pick_grant;
            SERVE_I: if (mem_resp) state_d = RELEASE;
            SERVE_D: if (mem_resp) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Adaptor command is a Moore function of the state plus the held request
    // of the granted side. A writeback takes precedence over a read if the
    // D-cache illegally raises both.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        case (state_q)
            SERVE_I: begin
                mem_read = 1'b1;
                mem_addr = i_addr;
                i_resp   = mem_resp;
            end
            SERVE_D: begin
                mem_read  = d_read & ~d_write;
                mem_write = d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_resp    = mem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_arbiter
//   Directed self-checking bench for cache_arbiter. Expected values are
//   written by hand for each step. When CACHE_ARB_RR_EN is defined the
//   tie-break expectations switch to alternating grants.
// ----------------------------------------------------------------------------
module tb_cache_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
    logic              busy;

    int checks;
    int failures;

`ifdef CACHE_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    cache_arbiter #(
        .LINE_W (LINE_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp),
        .busy      (busy)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag,
                                input logic [LINE_W-1:0] observed,
                                input logic [LINE_W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    logic [LINE_W-1:0] pat_a5;
    logic [LINE_W-1:0] pat_wb;
    logic [LINE_W-1:0] pat_d1;
    logic [LINE_W-1:0] pat_i1;
    logic [LINE_W-1:0] pat_lp;
    int                cyc;
    int                d_resp_cyc;
    int                i_resp_cyc;
    logic              exp_i_side;

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        d_resp_cyc = 0;
        i_resp_cyc = 0;
        pat_a5     = {32{8'hA5}};
        pat_wb     = {8{32'h1234_5678}};
        pat_d1     = {8{32'hDEAD_BEEF}};
        pat_i1     = {8{32'hCAFE_F00D}};
        pat_lp     = {8{32'h0BAD_F00D}};

        rst       = 1'b0;
        i_read    = 1'b0;
        i_addr    = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_resp  = 1'b0;

        // Reset state.
        tick();
        tick();
        check_output("rst_busy", busy, 0);
        check_output("rst_mem_read", mem_read, 0);
        check_output("rst_mem_write", mem_write, 0);
        rst = 1'b1;
        tick();
        check_output("idle_busy", busy, 0);

        // I-cache read only.
        i_read = 1'b1;
        i_addr = 32'h0000_1040;
        #1;
        check_output("i_no_comb_path", mem_read, 0);
        tick();
        check_output("i_mem_read", mem_read, 1);
        check_output("i_mem_addr", mem_addr, 32'h0000_1040);
        check_output("i_mem_write", mem_write, 0);
        check_output("i_busy", busy, 1);
        tick();
        tick();
        tick();
        tick();
        check_output("i_mem_read_held", mem_read, 1);
        check_output("i_resp_early", i_resp, 0);
        mem_resp  = 1'b1;
        mem_rdata = pat_a5;
        #1;
        check_output("i_resp", i_resp, 1);
        check_output("i_d_resp", d_resp, 0);
        check_output("i_rdata", i_rdata, pat_a5);
        tick();
        mem_resp = 1'b0;
        check_output("i_release_mem_read", mem_read, 0);
        check_output("i_release_resp", i_resp, 0);
        check_output("i_release_busy", busy, 1);
        tick();
        i_read = 1'b0;
        check_output("i_back_idle", busy, 0);
        tick();
        check_output("i_no_reissue", mem_read, 0);

        // D-cache writeback.
        d_write = 1'b1;
        d_addr  = 32'h0000_2000;
        d_wdata = pat_wb;
        tick();
        check_output("wb_mem_write", mem_write, 1);
        check_output("wb_mem_read", mem_read, 0);
        check_output("wb_mem_addr", mem_addr, 32'h0000_2000);
        check_output("wb_mem_wdata", mem_wdata, pat_wb);
        tick();
        mem_resp = 1'b1;
        #1;
        check_output("wb_d_resp", d_resp, 1);
        check_output("wb_i_resp", i_resp, 0);
        tick();
        mem_resp = 1'b0;
        check_output("wb_release_write", mem_write, 0);
        check_output("wb_release_wdata", mem_wdata, 0);
        tick();
        d_write = 1'b0;
        check_output("wb_back_idle", busy, 0);

        // Reset in the middle of a writeback.
        d_write = 1'b1;
        d_addr  = 32'h0000_5000;
        d_wdata = pat_wb;
        tick();
        check_output("mid_mem_write", mem_write, 1);
        #2;
        rst = 1'b0;
        #1;
        check_output("mid_rst_write", mem_write, 0);
        check_output("mid_rst_busy", busy, 0);
        check_output("mid_rst_addr", mem_addr, 0);
        d_write = 1'b0;
        rst     = 1'b1;
        tick();
        check_output("mid_after_busy", busy, 0);
        tick();
        check_output("mid_after_write", mem_write, 0);

        // Spurious mem_resp while idle.
        mem_resp = 1'b1;
        #1;
        check_output("spur_i_resp", i_resp, 0);
        check_output("spur_d_resp", d_resp, 0);
        tick();
        mem_resp = 1'b0;
        check_output("spur_busy", busy, 0);

        // Simultaneous I and D reads: D first in both modes after reset.
        i_read = 1'b1;
        i_addr = 32'h0000_3000;
        d_read = 1'b1;
        d_addr = 32'h0000_4000;
        tick();
        cyc = 1;
        check_output("sim_first_addr", mem_addr, 32'h0000_4000);
        check_output("sim_first_read", mem_read, 1);
        mem_resp  = 1'b1;
        mem_rdata = pat_d1;
        #1;
        check_output("sim_d_resp", d_resp, 1);
        check_output("sim_i_resp_early", i_resp, 0);
        check_output("sim_d_rdata", d_rdata, pat_d1);
        d_resp_cyc = cyc;
        tick();
        cyc++;
        mem_resp = 1'b0;
        d_read   = 1'b0;
        check_output("sim_release_read", mem_read, 0);
        tick();
        cyc++;
        check_output("sim_idle_read", mem_read, 0);
        tick();
        cyc++;
        check_output("sim_second_addr", mem_addr, 32'h0000_3000);
        check_output("sim_second_read", mem_read, 1);
        mem_resp  = 1'b1;
        mem_rdata = pat_i1;
        #1;
        check_output("sim_i_resp", i_resp, 1);
        check_output("sim_i_rdata", i_rdata, pat_i1);
        i_resp_cyc = cyc;
        check_output("sim_resp_gap_ge2", (i_resp_cyc - d_resp_cyc) >= 2, 1);
        tick();
        mem_resp = 1'b0;
        i_read   = 1'b0;
        tick();
        check_output("sim_back_idle", busy, 0);

        // Both requests held continuously: RR alternates D,I,D,I; fixed is D only.
        i_read = 1'b1;
        i_addr = 32'h0000_6000;
        d_read = 1'b1;
        d_addr = 32'h0000_7000;
        for (int g = 0; g < 4; g++) begin
            exp_i_side = RR_MODE && (g % 2 == 1);
            tick();
            check_output($sformatf("loop%0d_addr", g), mem_addr,
                         exp_i_side ? 32'h0000_6000 : 32'h0000_7000);
            mem_resp  = 1'b1;
            mem_rdata = pat_lp;
            #1;
            check_output($sformatf("loop%0d_i_resp", g), i_resp, exp_i_side);
            check_output($sformatf("loop%0d_d_resp", g), d_resp, !exp_i_side);
            tick();
            mem_resp = 1'b0;
            tick();
        end
        i_read = 1'b0;
        d_read = 1'b0;
        tick();
        tick();
        check_output("end_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
